// File: rtl/elevator_call_manager.sv
// elevator_call_manager: two-floor call latch and request sequencer; define ELEV_CALL_RETRY_EN to re-issue unserved requests
module elevator_call_manager #(
  parameter int RETRY_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn0,
  input  logic       btn1,
  input  logic       floor,
  input  logic       moving,
  output logic       req0,
  output logic       req1,
  output logic [1:0] pending,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, s3, clr;
  logic target, target_n, served, retry;
  assign clr = {floor & ~moving, ~floor & ~moving};
  assign served = (floor == target) && !moving;
  assign busy = state != IDLE;
`ifdef ELEV_CALL_RETRY_EN
  logic [7:0] cnt;
  assign retry = cnt == 8'(RETRY_CYCLES - 1);
  // wait counter held at zero outside WAIT so it restarts on every entry
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= state == WAIT ? cnt + 8'd1 : 8'd0;
`else
  assign retry = 1'b0;
`endif
  // synchronize buttons, detect rising edges, latch calls; arrival clears win over new presses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      pending <= '0;
    end else begin
      s1 <= {btn1, btn0};
      s2 <= s1;
      s3 <= s2;
      pending <= (pending | (s2 & ~s3)) & ~clr;
    end
  // next state: dispatch the opposite-floor call when idle, hold in WAIT until served
  always_comb begin
    state_n = state;
    target_n = target;
    case (state)
      IDLE: begin
        state_n = pending[~floor] && !moving ? ISSUE : IDLE;
        target_n = pending[~floor] && !moving ? ~floor : target;
      end
      ISSUE: state_n = WAIT;
      WAIT: state_n = served ? IDLE : retry ? ISSUE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // state, target and registered request pulses aligned with ISSUE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      target <= 1'b0;
      req0 <= 1'b0;
      req1 <= 1'b0;
    end else begin
      state <= state_n;
      target <= target_n;
      req0 <= state_n == ISSUE && !target_n;
      req1 <= state_n == ISSUE && target_n;
    end
endmodule
